// File: rtl/bin2bcd_pkg.sv
// Shared constants for the binary-to-BCD peripheral.
// Register addresses and core FSM states.
package bin2bcd_pkg;

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_INIT   = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;
  localparam logic [4:0] ADDR_DONE   = 5'h14;
  localparam logic [4:0] ADDR_BUSY   = 5'h18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble core: one add-3/shift step per clock.
// Converts an N_BITS operand into N_DIGITS packed BCD digits.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [N_BITS-1:0]     A,
  output logic [4*N_DIGITS-1:0] result,
  output logic                  done,
  output logic                  busy
);

  localparam int RW = 4 * N_DIGITS;
  localparam int SW = RW + N_BITS;
  localparam int CW = $clog2(N_BITS + 1);

  state_t        state;
  logic          init_q;
  logic [CW-1:0] count;
  logic [SW-1:0] sr;
  logic [SW-1:0] adj;
  logic [SW-1:0] shifted;
  logic          start;

  assign start = init && !init_q;

  always_comb begin
    adj = sr;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sr[N_BITS+4*i +: 4] >= 4'd5)
        adj[N_BITS+4*i +: 4] = sr[N_BITS+4*i +: 4] + 4'd3;
    end
    shifted = {adj[SW-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      init_q <= 1'b0;
      count  <= '0;
      sr     <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      init_q <= init;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sr    <= {{RW{1'b0}}, A};
            count <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= shifted;
          count <= count + 1'b1;
          if (count == CW'(N_BITS - 1)) begin
            result <= shifted[SW-1 -: RW];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_bin2bcd.sv
// femtoRV bus wrapper around the double-dabble core.
// Bus registers update on the falling clock edge.
module peripheral_bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  logic [N_BITS-1:0]     a_reg;
  logic                  init_reg;
  logic [4*N_DIGITS-1:0] result;
  logic                  done;
  logic                  busy;
  logic                  sel_a;
  logic                  sel_init;
  logic                  sel_res;
  logic                  sel_done;
  logic                  sel_busy;
  logic [31:0]           rdata;
  logic                  unused_bits;

  // Reads are qualified by cs alone; rd and upper data bits are spare.
  assign unused_bits = ^{rd, d_in};

  assign sel_a    = addr == ADDR_A;
  assign sel_init = addr == ADDR_INIT;
  assign sel_res  = addr == ADDR_RESULT;
  assign sel_done = addr == ADDR_DONE;
  assign sel_busy = addr == ADDR_BUSY;

  always_comb begin
    rdata = d_out;
    unique case (1'b1)
      sel_a:    rdata = 32'(a_reg);
      sel_res:  rdata = 32'(result);
      sel_done: rdata = {31'd0, done};
      sel_busy: rdata = {31'd0, busy};
      default:  rdata = d_out;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      init_reg <= 1'b0;
      d_out    <= '0;
    end else begin
      if (cs && wr) begin
        if (sel_a)    a_reg    <= d_in[N_BITS-1:0];
        if (sel_init) init_reg <= d_in[0];
      end
      if (cs) d_out <= rdata;
    end
  end

  bin2bcd #(
    .N_BITS   (N_BITS),
    .N_DIGITS (N_DIGITS)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .init   (init_reg),
    .A      (a_reg),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

endmodule

// File: doc/peripheral_bin2bcd.md
Name: peripheral_bin2bcd

Overview:
Memory-mapped femtoRV peripheral that converts an unsigned binary operand into packed BCD using a sequential shift-and-add-3 (double-dabble) engine. It is the inverse companion of the BCD-to-binary peripheral and shares its bus protocol: chip select, 5-bit address, rd/wr strobes and a 32-bit read-data return. Software writes the operand, pulses init, polls done, then reads the BCD result.

Parameters:
N_BITS, 16, binary operand width; equals the number of shift iterations.
N_DIGITS, 5, number of BCD digits in the result. Must satisfy 10^N_DIGITS > 2^N_BITS-1. Result width is 4*N_DIGITS and must be ≤ 32.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
d_in  input  32  bus write data
cs  input  1  peripheral chip select
addr  input  5  register address (low bits of the CPU address)
rd  input  1  bus read strobe
wr  input  1  bus write strobe
d_out  output  32  bus read data (registered)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high; every flop clears immediately when reset rises.
- Register map, decoded combinationally when cs=1:
  - 0x04: A, RW, bits [N_BITS-1:0].
  - 0x0C: init, W, bit 0.
  - 0x10: result, R, bits [4*N_DIGITS-1:0], zero-extended.
  - 0x14: done, R, bit 0.
  - 0x18: busy, R, bit 0.
  - Other addresses decode to none.
- Bus side, falling edge of clk:
  - When cs&&wr, the selected writable register loads from d_in.
  - When cs, d_out loads the selected readable register. Unselected or unmapped addresses hold d_out.
  - Reset values: A=0, init=0, d_out=0.
- Core, rising edge of clk. States: IDLE, SHIFT, DONE. Reset values: IDLE, done=0, busy=0, result=0, count=0.
- Start condition: core samples init into init_q every cycle. A start is a rising edge of init (init=1, init_q=0) while in IDLE or DONE.
  - On start: shift register = {zeros(4*N_DIGITS), A}, count=0, done=0, busy=1, state goes to SHIFT.
  - A is captured at start. Later writes to A do not affect the running conversion.
- SHIFT, each cycle:
  - Every BCD nibble ≥5 gets +3.
  - The whole shift register then shifts left by 1.
  - count increments.
  - After iteration N_BITS (count reaches N_BITS-1 and performs its step), result loads the upper 4*N_DIGITS bits, done=1, busy=0, state goes to DONE.
- Latency: done rises on the N_BITS-th rising edge after the start edge. That is 16 cycles for the defaults, 17 edges after init is first seen high.
- result holds its previous value throughout a conversion. It changes only at completion.
- DONE: holds result and done=1 until the next start, which clears done.
- init held high never retriggers; it must return to 0 and rise again.
- An init rising edge during SHIFT is ignored, and init_q still tracks init.
- Reset mid-conversion aborts immediately. Everything returns to its reset value, and no result is produced.
- Digits beyond the value's magnitude read as 0.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - Address constants ADDR_A=5'h04, ADDR_INIT=5'h0C, ADDR_RESULT=5'h10, ADDR_DONE=5'h14, ADDR_BUSY=5'h18.
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- One sub-module, bin2bcd: the double-dabble core with ports clk, reset, init, A, result, done, busy.
- The wrapper contains only the address decode, bus registers and read mux.

Test Plan:
- Write A=0, pulse init → done=1 after 16 cycles; result reads 0x00000000, busy 0.
- Write A=1234 (0x04D2), pulse init, poll done → result 0x00001234.
- Write A=65535, pulse init → result 0x00065535.
- Hold init=1 across two conversions' worth of cycles → exactly one conversion. Rewrite A=42 mid-conversion → result still reflects the old A. A fresh init 0→1 then gives 0x00000042.
- Start A=9999, assert reset for 1 cycle at iteration 8 → done=0, result=0, busy=0, d_out=0. A new start with A=7 gives 0x00000007.
- Read result at cycle 5 of a conversion with prior result 0x00001234 → d_out=0x00001234. Read of an unmapped address 0x1C leaves d_out unchanged.
